// File: rtl/alu_op_decode_stage.sv
// Registered RV32I decode stage: turns one instruction per handshake into an
// ALU op code, immediate and register indices, presented through a 2-entry
// skid buffer. Also keeps a saturating count of accepted illegal words.
module alu_op_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_op,
    output logic             out_use_imm,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    // Entry layout: {illegal, use_imm, alu_op, imm, rs1, rs2, rd}
    localparam int EW = 1 + 1 + 4 + XLEN + 15;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // Shared f3 -> ALU op mapping for R and I types; alt selects SUB/SRA.
    function automatic logic [3:0] map_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  map_f3 = alt ? 4'b0001 : 4'b0000;
            3'b001:  map_f3 = 4'b0101;
            3'b010:  map_f3 = 4'b1000;
            3'b011:  map_f3 = 4'b1001;
            3'b100:  map_f3 = 4'b0100;
            3'b101:  map_f3 = alt ? 4'b0111 : 4'b0110;
            3'b110:  map_f3 = 4'b0011;
            default: map_f3 = 4'b0010;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [3:0]      dec_alu_op;
    logic            dec_use_imm;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic [EW-1:0]   dec_entry;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    // Combinational decode of the incoming instruction word.
    always_comb begin
        dec_alu_op  = 4'b0000;
        dec_use_imm = 1'b0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                if (f7 == 7'b0 || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)))
                    dec_alu_op = map_f3(f3, f7[5]);
                else
                    dec_illegal = 1'b1;
            end
            OP_I: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    if (f7 == 7'b0 || (f7 == F7_ALT && f3 == 3'b101)) begin
                        dec_alu_op  = map_f3(f3, f7[5]);
                        dec_use_imm = 1'b1;
                        dec_imm     = {27'b0, in_instr[24:20]};
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else begin
                    // f3=000 is ADDI regardless of the upper immediate bits
                    dec_alu_op  = map_f3(f3, 1'b0);
                    dec_use_imm = 1'b1;
                    dec_imm     = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            OP_LOAD: begin
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_use_imm = 1'b1;
                    dec_imm     = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            OP_STORE: begin
                if (f3[2] || f3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_use_imm = 1'b1;
                    dec_imm     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                end
            end
            OP_BRANCH: begin
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_alu_op = !f3[2] ? 4'b0001 : (f3[1] ? 4'b1001 : 4'b1000);
                    dec_imm    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0};
                end
            end
            OP_LUI: begin
                dec_use_imm = 1'b1;
                dec_imm     = {in_instr[31:12], 12'b0};
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_entry = {dec_illegal, dec_use_imm, dec_alu_op, dec_imm,
                        in_instr[19:15], in_instr[24:20], in_instr[11:7]};

    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic [EW-1:0]    a_data_q, a_data_d;
    logic [EW-1:0]    b_data_q, b_data_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_in;

    assign do_in = in_valid && in_ready_q;

    // Skid-buffer steering and saturating illegal counter.
    always_comb begin
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;
        cnt_d     = cnt_q;
        if (a_valid_q && !out_ready) begin
            // A stalled: a new entry can only land in B (B is empty whenever in_ready)
            if (do_in) begin
                b_valid_d = 1'b1;
                b_data_d  = dec_entry;
            end
        end else if (b_valid_q) begin
            // A draining with B full: promote B; in_ready is low so no new input
            a_valid_d = 1'b1;
            a_data_d  = b_data_q;
            b_valid_d = 1'b0;
        end else if (do_in) begin
            a_valid_d = 1'b1;
            a_data_d  = dec_entry;
        end else begin
            a_valid_d = 1'b0;
        end
        if (do_in && dec_illegal && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
        in_ready_d = !b_valid_d;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            a_data_q   <= '0;
            b_data_q   <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            b_valid_q  <= b_valid_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = a_valid_q;
    assign illegal_count = cnt_q;
    assign {out_illegal, out_use_imm, out_alu_op, out_imm,
            out_rs1, out_rs2, out_rd} = a_data_q;

endmodule

// File: tb/tb_alu_op_decode_stage.sv
// Directed bench for alu_op_decode_stage with immediate-assertion checks.
module tb_alu_op_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_alu_op;
    logic        out_use_imm;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_illegal;
    logic [7:0]  illegal_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_decode_stage #(.XLEN(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_use_imm(out_use_imm), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one cycle (caller guarantees in_ready)
    task automatic send(input logic [31:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        $display("txn instr=%08h in_ready=%0b out_ready=%0b", instr, in_ready, out_ready);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] op, input logic ui,
                           input logic [31:0] imm, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic ill);
        chk({tag, ".valid"},   {31'b0, out_valid},   32'd1);
        chk({tag, ".alu_op"},  {28'b0, out_alu_op},  {28'b0, op});
        chk({tag, ".use_imm"}, {31'b0, out_use_imm}, {31'b0, ui});
        chk({tag, ".imm"},     out_imm,              imm);
        chk({tag, ".rs1"},     {27'b0, out_rs1},     {27'b0, rs1});
        chk({tag, ".rs2"},     {27'b0, out_rs2},     {27'b0, rs2});
        chk({tag, ".rd"},      {27'b0, out_rd},      {27'b0, rd});
        chk({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst.count",     {24'b0, illegal_count}, 32'd0);
        chk("rst.alu_op",    {28'b0, out_alu_op}, 32'd0);
        chk("rst.imm",       out_imm, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // add x3,x1,x2
        send(32'h002081B3);
        chk_out("add", 4'b0000, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        chk("add.drained", {31'b0, out_valid}, 32'd0);

        // sub then srai back-to-back
        in_valid = 1'b1;
        in_instr = 32'h402081B3;
        $display("txn instr=%08h back-to-back", in_instr);
        tick();
        chk_out("sub", 4'b0001, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0);
        in_instr = 32'h40335293;
        $display("txn instr=%08h back-to-back", in_instr);
        tick();
        chk_out("srai", 4'b0111, 1'b1, 32'h3, 5'd6, 5'd3, 5'd5, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("srai.drained", {31'b0, out_valid}, 32'd0);

        // Backpressure: fill A and B, third word held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3;
        $display("txn instr=%08h stalled", in_instr);
        tick();
        chk("bp1.in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp1.rd", {27'b0, out_rd}, 32'd3);
        in_instr = 32'h402081B3;
        $display("txn instr=%08h stalled", in_instr);
        tick();
        chk("bp2.in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp2.hold_op", {28'b0, out_alu_op}, 32'd0);
        in_instr = 32'h00000033;
        $display("txn instr=%08h held", in_instr);
        tick();
        chk("bp3.in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp3.valid", {31'b0, out_valid}, 32'd1);
        chk("bp3.hold_op", {28'b0, out_alu_op}, 32'd0);
        chk("bp3.hold_rd", {27'b0, out_rd}, 32'd3);
        out_ready = 1'b1;
        tick();
        chk_out("bp.second", 4'b0001, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("bp.in_ready_back", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk_out("bp.third", 4'b0000, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        chk("bp.empty", {31'b0, out_valid}, 32'd0);

        // Branches
        send(32'h0020E463);
        chk_out("bltu", 4'b1001, 1'b0, 32'h8, 5'd1, 5'd2, 5'd8, 1'b0);
        send(32'h00209463);
        chk_out("bne", 4'b0001, 1'b0, 32'h8, 5'd1, 5'd2, 5'd8, 1'b0);

        // Load / store / LUI immediates
        send(32'hFFC12283);
        chk_out("lw", 4'b0000, 1'b1, 32'hFFFFFFFC, 5'd2, 5'd28, 5'd5, 1'b0);
        send(32'h0020A423);
        chk_out("sw", 4'b0000, 1'b1, 32'h8, 5'd1, 5'd2, 5'd8, 1'b0);
        send(32'h123453B7);
        chk_out("lui", 4'b0000, 1'b1, 32'h12345000, 5'd8, 5'd3, 5'd7, 1'b0);

        // Illegal words
        send(32'hFFFFFFFF);
        chk_out("ill_ff", 4'b0000, 1'b0, 32'h0, 5'd31, 5'd31, 5'd31, 1'b1);
        chk("ill_ff.count", {24'b0, illegal_count}, 32'd1);
        send(32'h0220A0B3);
        chk_out("ill_f7", 4'b0000, 1'b0, 32'h0, 5'd1, 5'd2, 5'd1, 1'b1);
        chk("ill_f7.count", {24'b0, illegal_count}, 32'd2);

        // Saturation: 300 more illegal words
        in_valid = 1'b1;
        in_instr = 32'hFFFFFFFF;
        for (int i = 0; i < 300; i++) begin
            $display("txn instr=%08h illegal #%0d", in_instr, i);
            tick();
            if (i == 100) chk("sat.mid_count", {24'b0, illegal_count}, 32'd103);
        end
        in_valid = 1'b0;
        chk("sat.count", {24'b0, illegal_count}, 32'd255);
        tick();

        // Fill both entries, then asynchronous reset mid-cycle
        out_ready = 1'b0;
        send(32'h002081B3);
        send(32'h402081B3);
        chk("fill.in_ready", {31'b0, in_ready}, 32'd0);
        chk("fill.valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst.in_ready",  {31'b0, in_ready},  32'd1);
        chk("arst.count",     {24'b0, illegal_count}, 32'd0);
        chk("arst.rd",        {27'b0, out_rd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post.empty", {31'b0, out_valid}, 32'd0);
        send(32'h40335293);
        chk_out("post.srai", 4'b0111, 1'b1, 32'h3, 5'd6, 5'd3, 5'd5, 1'b0);
        tick();
        chk("post.drained", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
